// File: rtl/rtc_malrm_core.sv
// Multi-alarm real-time counter: prescaled second counter, ALRM_NUM one-shot/periodic alarms,
// sticky interrupt flags and one registered irq. Define RTC_ALRM_MASK_EN for per-bit alarm masks.
module rtc_malrm_core #(
    parameter int CNT_WIDTH  = 32,
    parameter int PSCR_WIDTH = 20,
    parameter int ALRM_NUM   = 4
) (
    input  logic                      rtc_clk_i,
    input  logic                      rtc_rst_n_i,
    input  logic                      en_i,
    input  logic [PSCR_WIDTH-1:0]     pscr_i,
    input  logic                      cnt_wr_i,
    input  logic [CNT_WIDTH-1:0]      cnt_wdata_i,
    input  logic [ALRM_NUM-1:0]       alrm_wr_i,
    input  logic [CNT_WIDTH-1:0]      alrm_wdata_i,
    input  logic [ALRM_NUM-1:0]       alrm_mode_i,
    input  logic                      sc_ie_i,
    input  logic                      ov_ie_i,
    input  logic [ALRM_NUM-1:0]       alrm_ie_i,
    input  logic [ALRM_NUM+1:0]       ista_clr_i,
`ifdef RTC_ALRM_MASK_EN
    input  logic [ALRM_NUM*CNT_WIDTH-1:0] alrm_mask_i,
`endif
    output logic                      tick_o,
    output logic [CNT_WIDTH-1:0]      cnt_o,
    output logic [ALRM_NUM-1:0]       armed_o,
    output logic [ALRM_NUM+1:0]       ista_o,
    output logic                      irq_o
);

    localparam logic [PSCR_WIDTH-1:0] PSCR_MIN = PSCR_WIDTH'(2);

    logic [PSCR_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ALRM_NUM+1:0]   ista_q, ista_d;
    logic                  tick_q, irq_q, irq_d;

    logic [PSCR_WIDTH-1:0] pscr_eff;
    logic                  tick_raw, tick_eff, ov_set;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [ALRM_NUM-1:0]   fire;
    logic [ALRM_NUM-1:0]   armed_w;

    // The >= compare makes a lowered divisor take effect on the very next cycle.
    assign pscr_eff = (pscr_i < PSCR_MIN) ? PSCR_MIN : pscr_i;
    assign tick_raw = en_i && (div_q >= pscr_eff);
    assign tick_eff = tick_raw && !cnt_wr_i;
    assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
    assign ov_set   = tick_eff && (&cnt_q);

    always_comb begin
        div_d = div_q;
        if (cnt_wr_i || tick_raw) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = div_q + PSCR_WIDTH'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wr_i) begin
            cnt_d = cnt_wdata_i;
        end else if (tick_eff) begin
            cnt_d = cnt_inc;
        end
    end

    // Set wins over a same-cycle clear on every flag bit.
    assign ista_d = (ista_q & ~ista_clr_i) | {fire, ov_set, tick_eff};
    assign irq_d  = |(ista_q & {alrm_ie_i, ov_ie_i, sc_ie_i});

    generate
        for (genvar gi = 0; gi < ALRM_NUM; gi++) begin : g_alrm
            logic [CNT_WIDTH-1:0] alrm_q;
            logic                 armed_q;
            logic                 match;

`ifdef RTC_ALRM_MASK_EN
            assign match = ((cnt_inc ^ alrm_q) & ~alrm_mask_i[gi*CNT_WIDTH +: CNT_WIDTH]) == '0;
`else
            assign match = (cnt_inc == alrm_q);
`endif
            // A write on this channel suppresses a coincident match.
            assign fire[gi]    = tick_eff && armed_q && match && !alrm_wr_i[gi];
            assign armed_w[gi] = armed_q;

            always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
                if (!rtc_rst_n_i) begin
                    alrm_q  <= '0;
                    armed_q <= 1'b0;
                end else if (alrm_wr_i[gi]) begin
                    alrm_q  <= alrm_wdata_i;
                    armed_q <= 1'b1;
                end else if (fire[gi] && !alrm_mode_i[gi]) begin
                    armed_q <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            div_q  <= '0;
            cnt_q  <= '0;
            ista_q <= '0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            ista_q <= ista_d;
            tick_q <= tick_eff;
            irq_q  <= irq_d;
        end
    end

    assign tick_o  = tick_q;
    assign cnt_o   = cnt_q;
    assign armed_o = armed_w;
    assign ista_o  = ista_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_rtc_malrm_core.sv
// Bench for rtc_malrm_core: a 32-bit/4-alarm instance for the prescaler/counter vector table
// and a 4-bit/2-alarm instance for alarm wrap sequences.
module tb_rtc_malrm_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: CNT_WIDTH=32, ALRM_NUM=4
    logic        en_a, cnt_wr_a, sc_ie_a, ov_ie_a;
    logic [19:0] pscr_a;
    logic [31:0] cnt_wdata_a, alrm_wdata_a, cnt_a;
    logic [3:0]  alrm_wr_a, alrm_mode_a, alrm_ie_a, armed_a;
    logic [5:0]  clr_a, ista_a;
    logic        tick_a, irq_a;
    // Instance B: CNT_WIDTH=4, ALRM_NUM=2, PSCR_WIDTH=4
    logic        en_b, cnt_wr_b, sc_ie_b, ov_ie_b;
    logic [3:0]  pscr_b, cnt_wdata_b, alrm_wdata_b, cnt_b, clr_b, ista_b;
    logic [1:0]  alrm_wr_b, alrm_mode_b, alrm_ie_b, armed_b;
    logic        tick_b, irq_b;
`ifdef RTC_ALRM_MASK_EN
    logic [127:0] mask_a;
    logic [7:0]   mask_b;
`endif

    rtc_malrm_core #(.CNT_WIDTH(32), .PSCR_WIDTH(20), .ALRM_NUM(4)) u_a (
`ifdef RTC_ALRM_MASK_EN
        .alrm_mask_i(mask_a),
`endif
        .rtc_clk_i(clk), .rtc_rst_n_i(rst_n), .en_i(en_a), .pscr_i(pscr_a),
        .cnt_wr_i(cnt_wr_a), .cnt_wdata_i(cnt_wdata_a), .alrm_wr_i(alrm_wr_a),
        .alrm_wdata_i(alrm_wdata_a), .alrm_mode_i(alrm_mode_a), .sc_ie_i(sc_ie_a),
        .ov_ie_i(ov_ie_a), .alrm_ie_i(alrm_ie_a), .ista_clr_i(clr_a), .tick_o(tick_a),
        .cnt_o(cnt_a), .armed_o(armed_a), .ista_o(ista_a), .irq_o(irq_a)
    );

    rtc_malrm_core #(.CNT_WIDTH(4), .PSCR_WIDTH(4), .ALRM_NUM(2)) u_b (
`ifdef RTC_ALRM_MASK_EN
        .alrm_mask_i(mask_b),
`endif
        .rtc_clk_i(clk), .rtc_rst_n_i(rst_n), .en_i(en_b), .pscr_i(pscr_b),
        .cnt_wr_i(cnt_wr_b), .cnt_wdata_i(cnt_wdata_b), .alrm_wr_i(alrm_wr_b),
        .alrm_wdata_i(alrm_wdata_b), .alrm_mode_i(alrm_mode_b), .sc_ie_i(sc_ie_b),
        .ov_ie_i(ov_ie_b), .alrm_ie_i(alrm_ie_b), .ista_clr_i(clr_b), .tick_o(tick_b),
        .cnt_o(cnt_b), .armed_o(armed_b), .ista_o(ista_b), .irq_o(irq_b)
    );

    typedef struct packed {
        logic        en;
        logic [19:0] pscr;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  clr;
        logic        exp_tick;
        logic [31:0] exp_cnt;
        logic [1:0]  exp_ista;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic en, input logic [19:0] pscr, input logic wr, input logic [31:0] wd,
                     input logic [1:0] clr, input logic tk, input logic [31:0] cnt,
                     input logic [1:0] ista, input logic irq, input int n = 1);
        vec_t r;
        r = '{en, pscr, wr, wd, clr, tk, cnt, ista, irq};
        for (int i = 0; i < n; i++) vecs.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick_a();
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick_a) return;
        end
        check("tick_a_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_tick_b();
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick_b) return;
        end
        check("tick_b_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        vec_t cur, e;
        rst_n = 1'b0;
        en_a = 0; pscr_a = 0; cnt_wr_a = 0; cnt_wdata_a = 0; alrm_wr_a = 0; alrm_wdata_a = 0;
        alrm_mode_a = 0; sc_ie_a = 0; ov_ie_a = 1; alrm_ie_a = 0; clr_a = 0;
        en_b = 0; pscr_b = 0; cnt_wr_b = 0; cnt_wdata_b = 0; alrm_wr_b = 0; alrm_wdata_b = 0;
        alrm_mode_b = 0; sc_ie_b = 0; ov_ie_b = 0; alrm_ie_b = 0; clr_b = 0;
`ifdef RTC_ALRM_MASK_EN
        mask_a = '0; mask_b = '0;
`endif
        repeat (2) step();
        check("rst_tick", tick_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_armed", armed_a, 0);
        check("rst_ista", ista_a, 0);
        check("rst_irq", irq_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        rst_n = 1'b1;

        // Prescaler clamp, hold, load, overflow, irq, load-vs-tick, clear-vs-tick, pscr lowered.
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        v(1, 0, 0, 0, 0, 1, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        v(1, 0, 0, 0, 0, 1, 2, 1, 0);
        v(1, 0, 0, 0, 0, 0, 2, 1, 0, 2);
        v(1, 0, 0, 0, 0, 1, 3, 1, 0);
        v(1, 0, 0, 0, 2'b01, 0, 3, 0, 0);
        v(0, 0, 0, 0, 0, 0, 3, 0, 0, 2);
        v(1, 0, 0, 0, 0, 0, 3, 0, 0);
        v(1, 0, 0, 0, 0, 1, 4, 1, 0);
        v(1, 4, 1, 32'hFFFF_FFFE, 2'b01, 0, 32'hFFFF_FFFE, 0, 0);
        v(1, 4, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 4);
        v(1, 4, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        v(1, 4, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 4);
        v(1, 4, 0, 0, 0, 1, 0, 2'b11, 0);
        v(1, 4, 0, 0, 2'b10, 0, 0, 1, 1);
        v(1, 4, 0, 0, 0, 0, 0, 1, 0);
        v(1, 4, 0, 0, 2'b01, 0, 0, 0, 0);
        v(1, 4, 0, 0, 0, 0, 0, 0, 0);
        v(1, 4, 1, 32'h100, 0, 0, 32'h100, 0, 0);
        v(1, 4, 0, 0, 0, 0, 32'h100, 0, 0, 4);
        v(1, 4, 0, 0, 0, 1, 32'h101, 1, 0);
        v(1, 4, 0, 0, 0, 0, 32'h101, 1, 0, 4);
        v(1, 4, 0, 0, 2'b01, 1, 32'h102, 1, 0);
        v(1, 4, 0, 0, 2'b01, 0, 32'h102, 0, 0);
        v(1, 4, 0, 0, 0, 0, 32'h102, 0, 0);
        v(1, 0, 0, 0, 0, 1, 32'h103, 1, 0);

        foreach (vecs[i]) begin
            cur = vecs[i];
            en_a = cur.en; pscr_a = cur.pscr; cnt_wr_a = cur.wr; cnt_wdata_a = cur.wdata;
            clr_a = {4'b0, cur.clr};
            exp_q.push_back(cur);
            step();
            e = exp_q.pop_front();
            check($sformatf("v%0d_tick", i), tick_a, e.exp_tick);
            check($sformatf("v%0d_cnt", i), cnt_a, e.exp_cnt);
            check($sformatf("v%0d_ista", i), ista_a, {4'b0, e.exp_ista});
            check($sformatf("v%0d_irq", i), irq_a, e.exp_irq);
        end
        en_a = 0; cnt_wr_a = 0; clr_a = 0;

        // Alarm channels on the 4-bit counter: ch0 one-shot, ch1 periodic, both at 5.
        en_b = 1; pscr_b = 0; cnt_wr_b = 1; cnt_wdata_b = 0;
        alrm_wr_b = 2'b11; alrm_wdata_b = 4'd5; alrm_mode_b = 2'b10;
        step();
        cnt_wr_b = 0; alrm_wr_b = 0;
        check("b_armed_init", armed_b, 2'b11);
        check("b_load_cnt", cnt_b, 0);
        for (int i = 1; i <= 5; i++) begin
            wait_tick_b();
            check($sformatf("b_cnt_%0d", i), cnt_b, i);
            check($sformatf("b_alrmif_%0d", i), ista_b[3:2], (i == 5) ? 2'b11 : 2'b00);
        end
        check("b_armed_after_fire", armed_b, 2'b10);
        clr_b = 4'b1100;
        step();
        clr_b = 0;
        check("b_alrmif_cleared", ista_b[3:2], 2'b00);
        for (int j = 1; j <= 16; j++) begin
            wait_tick_b();
            check($sformatf("b_wrap_cnt_%0d", j), cnt_b, (5 + j) % 16);
            check($sformatf("b_wrap_alrmif_%0d", j), ista_b[3:2], (j == 16) ? 2'b10 : 2'b00);
        end
        check("b_ovif", ista_b[1], 1);
        check("b_armed_wrap", armed_b, 2'b10);

        // Write on the matching tick re-arms without setting the flag.
        clr_b = 4'b1100; alrm_wr_b = 2'b01; alrm_wdata_b = 4'd7;
        step();
        clr_b = 0; alrm_wr_b = 0;
        wait_tick_b();
        check("b_cnt6", cnt_b, 6);
        step();
        step();
        alrm_wr_b = 2'b01; alrm_wdata_b = 4'd7;
        step();
        alrm_wr_b = 0;
        check("b_wr_tick", tick_b, 1);
        check("b_wr_cnt", cnt_b, 7);
        check("b_wr_noflag", ista_b[2], 0);
        check("b_wr_armed", armed_b[0], 1);

`ifdef RTC_ALRM_MASK_EN
        en_a = 1; pscr_a = 0; cnt_wr_a = 1; cnt_wdata_a = 32'hE;
        alrm_wr_a = 4'b0001; alrm_wdata_a = 32'h10; alrm_mode_a = 4'b0001;
        mask_a = '0; mask_a[31:0] = 32'hF; clr_a = 6'b111111;
        step();
        cnt_wr_a = 0; alrm_wr_a = 0; clr_a = 0;
        for (int t = 1; t <= 19; t++) begin
            wait_tick_a();
            check($sformatf("m_cnt_%0d", t), cnt_a, 32'hE + t);
            check($sformatf("m_fire_%0h", 32'hE + t), ista_a[2],
                  ((32'hE + t) >= 32'h10 && (32'hE + t) <= 32'h1F) ? 1'b1 : 1'b0);
            clr_a = 6'b000100;
            step();
            clr_a = 0;
        end
        en_a = 0;
`endif

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt_a", cnt_a, 0);
        check("arst_ista_a", ista_a, 0);
        check("arst_cnt_b", cnt_b, 0);
        check("arst_armed_b", armed_b, 0);
        check("arst_ista_b", ista_b, 0);
        check("arst_irq_b", irq_b, 0);
        step();
        check("arst_tick_b", tick_b, 0);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
